gf180mcu_fd_sc_mcu7t5v0__regslice: RTL and testbench

Two-entry registered skid buffer that consumes the data word captured by a bank of negative-edge `dffnq` cells and hands it to positive-edge logic under valid/ready flow control. Sits directly downstream of the `dffnq` capture bank: the bank's Q outputs drive `IN_D`, and the slice presents a fully registered, back-pressurable stream on `OUT_Q`. Sustains one word per cycle with no combinational path from `OUT_READY` to `IN_READY`.

---
 rtl/gf180mcu_fd_sc_mcu7t5v0__regslice.sv | 156 +++++++++++++++
 tb/tb_gf180mcu_fd_sc_mcu7t5v0__regslice.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/gf180mcu_fd_sc_mcu7t5v0__regslice.sv
// gf180mcu_fd_sc_mcu7t5v0__regslice
//   Two-entry registered skid buffer. Takes the word captured by a
//   negative-edge dffnq bank and presents it as a fully registered,
//   back-pressurable valid/ready stream to rising-edge logic.
//   Sustains one word per cycle. IN_READY is a flop, so there is no
//   combinational path from OUT_READY to IN_READY.
//
// Ports
//   CLK        rising-edge clock
//   RST        synchronous active-high reset
//   IN_VALID   upstream word on IN_D is valid
//   IN_READY   slice accepts a word this cycle (registered)
//   IN_D       data word from the dffnq bank Q outputs
//   OUT_VALID  OUT_Q holds a valid word (registered)
//   OUT_READY  downstream accepts OUT_Q this cycle
//   OUT_Q      head word (registered)
//   COUNT      occupancy 0..2 (registered)
//   PAR        even parity of OUT_Q (only with the parity macro)
//
// Configuration
//   GF180MCU_FD_SC_MCU7T5V0__REGSLICE_PARITY_EN  adds one parity bit per
//   entry and the PAR output.

module gf180mcu_fd_sc_mcu7t5v0__regslice #(
    parameter int WIDTH = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             IN_VALID,
    output logic             IN_READY,
    input  logic [WIDTH-1:0] IN_D,
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    output logic [WIDTH-1:0] OUT_Q,
    output logic [1:0]       COUNT
`ifdef GF180MCU_FD_SC_MCU7T5V0__REGSLICE_PARITY_EN
    ,
    output logic             PAR
`endif
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_nxt;
    logic             r_in_ready;
    logic             r_out_valid;
    logic [WIDTH-1:0] r_main;
    logic [WIDTH-1:0] r_skid;

    logic w_in_fire;
    logic w_out_fire;
    logic w_ld_main;
    logic w_ld_skid;
    logic w_main_from_skid;

    assign w_in_fire  = IN_VALID & r_in_ready;
    assign w_out_fire = r_out_valid & OUT_READY;

    always_comb begin
        w_nxt            = r_state;
        w_ld_main        = 1'b0;
        w_ld_skid        = 1'b0;
        w_main_from_skid = 1'b0;
        case (r_state)
            EMPTY: begin
                if (w_in_fire) begin
                    w_ld_main = 1'b1;
                    w_nxt     = ONE;
                end
            end
            ONE: begin
                if (w_in_fire && w_out_fire) begin
                    // head leaves and new word takes its place
                    w_ld_main = 1'b1;
                end else if (w_in_fire) begin
                    w_ld_skid = 1'b1;
                    w_nxt     = FULL;
                end else if (w_out_fire) begin
                    w_nxt = EMPTY;
                end
            end
            FULL: begin
                if (w_out_fire) begin
                    w_ld_main        = 1'b1;
                    w_main_from_skid = 1'b1;
                    w_nxt            = ONE;
                end
            end
            default: w_nxt = EMPTY;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state     <= EMPTY;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            r_state     <= w_nxt;
            r_in_ready  <= (w_nxt != FULL);
            r_out_valid <= (w_nxt != EMPTY);
        end
    end

    // Main register is cleared so OUT_Q reads 0 after reset; its contents
    // are otherwise only meaningful while OUT_VALID is high.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_main <= '0;
        end else if (w_ld_main) begin
            r_main <= w_main_from_skid ? r_skid : IN_D;
        end
    end

    // Skid entry is never reset; it is only read when state says it is live.
    always_ff @(posedge CLK) begin
        if (w_ld_skid) begin
            r_skid <= IN_D;
        end
    end

`ifdef GF180MCU_FD_SC_MCU7T5V0__REGSLICE_PARITY_EN
    logic r_main_par;
    logic r_skid_par;
    logic w_in_par;

    assign w_in_par = ^IN_D;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_main_par <= 1'b0;
        end else if (w_ld_main) begin
            r_main_par <= w_main_from_skid ? r_skid_par : w_in_par;
        end
    end

    always_ff @(posedge CLK) begin
        if (w_ld_skid) begin
            r_skid_par <= w_in_par;
        end
    end

    assign PAR = r_main_par;
`endif

    assign IN_READY  = r_in_ready;
    assign OUT_VALID = r_out_valid;
    assign OUT_Q     = r_main;
    assign COUNT     = r_state;

endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu7t5v0__regslice.sv
// Self-checking bench for the two-entry register slice. A queue holding at
// most two words models the slice; every cycle the DUT outputs are compared
// against the queue, with directed sequences followed by random traffic.

module tb_gf180mcu_fd_sc_mcu7t5v0__regslice;

    localparam int WIDTH = 8;

    logic             CLK = 1'b0;
    logic             RST;
    logic             IN_VALID;
    logic             IN_READY;
    logic [WIDTH-1:0] IN_D;
    logic             OUT_VALID;
    logic             OUT_READY;
    logic [WIDTH-1:0] OUT_Q;
    logic [1:0]       COUNT;
`ifdef GF180MCU_FD_SC_MCU7T5V0__REGSLICE_PARITY_EN
    logic             PAR;
`endif

    gf180mcu_fd_sc_mcu7t5v0__regslice #(.WIDTH(WIDTH)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .IN_VALID  (IN_VALID),
        .IN_READY  (IN_READY),
        .IN_D      (IN_D),
        .OUT_VALID (OUT_VALID),
        .OUT_READY (OUT_READY),
        .OUT_Q     (OUT_Q),
        .COUNT     (COUNT)
`ifdef GF180MCU_FD_SC_MCU7T5V0__REGSLICE_PARITY_EN
        ,
        .PAR       (PAR)
`endif
    );

    always #5 CLK = ~CLK;

    int n_chk = 0;
    int n_err = 0;
    bit known = 1'b0;
    logic [WIDTH-1:0] q[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Drive one cycle, check outputs against the model, then advance the model.
    task automatic cyc(input bit rst, input bit iv, input logic [WIDTH-1:0] d, input bit ordy);
        bit fi, fo;
        RST       = rst;
        IN_VALID  = iv;
        IN_D      = d;
        OUT_READY = ordy;
        #3;
        if (known) begin
            chk("out_valid", {63'd0, OUT_VALID}, {63'd0, q.size() != 0});
            chk("in_ready",  {63'd0, IN_READY},  {63'd0, q.size() != 2});
            chk("count",     {62'd0, COUNT},     64'(q.size()));
            if (q.size() != 0) begin
                chk("out_q", 64'(OUT_Q), 64'(q[0]));
`ifdef GF180MCU_FD_SC_MCU7T5V0__REGSLICE_PARITY_EN
                chk("par", {63'd0, PAR}, {63'd0, ^q[0]});
`endif
            end
        end
        fi = !rst && iv && (q.size() < 2);
        fo = !rst && ordy && (q.size() > 0);
        @(posedge CLK);
        if (rst) begin
            q.delete();
            known = 1'b1;
        end else begin
            if (fo) void'(q.pop_front());
            if (fi) q.push_back(d);
        end
        #1;
    endtask

    initial begin
        RST = 1'b1; IN_VALID = 1'b0; IN_D = '0; OUT_READY = 1'b0;
        #1;

        // Reset with a handshake offered: must be discarded
        cyc(1, 1, 8'hA5, 1);
        cyc(1, 1, 8'hA5, 1);
        chk("rst_out_q", 64'(OUT_Q), 64'h0);
        chk("rst_count", {62'd0, COUNT}, 64'd0);
        chk("rst_valid", {63'd0, OUT_VALID}, 64'd0);
        chk("rst_ready", {63'd0, IN_READY}, 64'd1);
`ifdef GF180MCU_FD_SC_MCU7T5V0__REGSLICE_PARITY_EN
        chk("rst_par", {63'd0, PAR}, 64'd0);
`endif
        cyc(0, 0, 8'h00, 1);
        cyc(0, 0, 8'h00, 1);

        // Streaming 01..10
        for (int i = 1; i <= 16; i++) cyc(0, 1, 8'(i), 1);
        cyc(0, 0, 8'h00, 1);
        cyc(0, 0, 8'h00, 1);

        // Fill / back-pressure
        cyc(0, 1, 8'h11, 0);
        cyc(0, 1, 8'h22, 0);
        cyc(0, 1, 8'h33, 0);
        chk("full_count", {62'd0, COUNT}, 64'd2);
        chk("full_ready", {63'd0, IN_READY}, 64'd0);
        chk("full_head", 64'(OUT_Q), 64'h11);
        cyc(0, 0, 8'h00, 1);
        cyc(0, 0, 8'h00, 1);
        cyc(0, 0, 8'h00, 1);

        // Simultaneous fire in ONE
        cyc(0, 1, 8'h44, 0);
        cyc(0, 1, 8'h55, 1);
        chk("sim_count", {62'd0, COUNT}, 64'd1);
        chk("sim_head", 64'(OUT_Q), 64'h55);
        cyc(0, 0, 8'h00, 1);

        // Reset while FULL
        cyc(0, 1, 8'h66, 0);
        cyc(0, 1, 8'h77, 0);
        cyc(1, 0, 8'h00, 0);
        chk("rstf_count", {62'd0, COUNT}, 64'd0);
        chk("rstf_valid", {63'd0, OUT_VALID}, 64'd0);
        for (int i = 0; i < 3; i++) cyc(0, 0, 8'h00, 1);

        // Parity pair
        cyc(0, 1, 8'h03, 1);
        cyc(0, 1, 8'h07, 1);
        cyc(0, 0, 8'h00, 1);

        // Random traffic with occasional reset
        for (int i = 0; i < 3000; i++) begin
            cyc(($urandom_range(0, 199) == 0),
                ($urandom_range(0, 9) < 7),
                8'($urandom),
                ($urandom_range(0, 9) < 6));
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
